// File: rtl/i2c_write_sequencer_pkg.sv
// i2c_seq_pkg: shared constants, FSM encoding and table entry layout
// for the I2C init write sequencer (optional host port: I2C_SEQ_HOST_PORT_EN).
package i2c_seq_pkg;

  localparam int         ENTRY_W   = 24;
  localparam logic [7:0] END_MARK  = 8'hFF;
  localparam int         RETRY_GAP = 16;

  typedef enum logic [3:0] {
    S_PWRUP   = 4'd0,
    S_FETCH   = 4'd1,
    S_GO_HI   = 4'd2,
    S_WAIT_LO = 4'd3,
    S_WAIT_HI = 4'd4,
    S_CHECK   = 4'd5,
    S_RETRY   = 4'd6,
    S_DONE    = 4'd7,
    S_ERR     = 4'd8
  } state_t;

  typedef struct packed {
    logic [7:0] slave;
    logic [7:0] ptr;
    logic [7:0] data;
  } entry_t;

endpackage

// File: rtl/i2c_write_sequencer_if.sv
// Engine handshake, write bus and status bundle of the init sequencer.
// Host request signals exist only with I2C_SEQ_HOST_PORT_EN defined.
interface i2c_write_sequencer_if;

  logic       END_OK;
  logic       ACK_OK;
  logic       GO;
  logic [7:0] SLAVE_ADDRESS;
  logic [7:0] POINTER;
  logic [7:0] WDATA8;
  logic       INIT_DONE;
  logic       INIT_ERR;
  logic [7:0] ERR_INDEX;

`ifdef I2C_SEQ_HOST_PORT_EN
  logic       HOST_REQ;
  logic [7:0] HOST_SLAVE;
  logic [7:0] HOST_PTR;
  logic [7:0] HOST_DATA;
  logic       HOST_ACK;
  logic       HOST_NACK;

  modport master (
    input  END_OK, ACK_OK,
    input  HOST_REQ, HOST_SLAVE,
    input  HOST_PTR, HOST_DATA,
    output GO, SLAVE_ADDRESS,
    output POINTER, WDATA8,
    output INIT_DONE, INIT_ERR,
    output ERR_INDEX,
    output HOST_ACK, HOST_NACK
  );

  modport slave (
    output END_OK, ACK_OK,
    output HOST_REQ, HOST_SLAVE,
    output HOST_PTR, HOST_DATA,
    input  GO, SLAVE_ADDRESS,
    input  POINTER, WDATA8,
    input  INIT_DONE, INIT_ERR,
    input  ERR_INDEX,
    input  HOST_ACK, HOST_NACK
  );
`else
  modport master (
    input  END_OK, ACK_OK,
    output GO, SLAVE_ADDRESS,
    output POINTER, WDATA8,
    output INIT_DONE, INIT_ERR,
    output ERR_INDEX
  );

  modport slave (
    output END_OK, ACK_OK,
    input  GO, SLAVE_ADDRESS,
    input  POINTER, WDATA8,
    input  INIT_DONE, INIT_ERR,
    input  ERR_INDEX
  );
`endif

endinterface

// File: rtl/i2c_write_sequencer_rom.sv
// i2c_seq_rom: constant init table, idx -> {slave, pointer, data}.
// Unused slots read as END_MARK so the walk stops there.
module i2c_seq_rom
  import i2c_seq_pkg::*;
(
  input  logic [7:0] idx,
  output entry_t     entry
);

  always_comb begin
    entry = '{slave: END_MARK, ptr: 8'h00, data: 8'h00};
    case (idx)
      8'd0:    entry = '{slave: 8'h34, ptr: 8'h10, data: 8'h01};
      8'd1:    entry = '{slave: 8'h34, ptr: 8'h11, data: 8'h22};
      8'd2:    entry = '{slave: 8'h1A, ptr: 8'h05, data: 8'h7F};
      default: entry = '{slave: END_MARK, ptr: 8'h00, data: 8'h00};
    endcase
  end

endmodule

// File: rtl/i2c_write_sequencer.sv
// i2c_write_sequencer: walks the init table through the byte-write engine
// with ACK check and retries; host port enabled by I2C_SEQ_HOST_PORT_EN.
module i2c_write_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int N_ENTRIES = 8,
  parameter int PWRUP_DLY = 255,
  parameter int GO_HOLD   = 2,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 1023
) (
  input logic PT_CK,
  input logic RESET_N,
  i2c_write_sequencer_if.master bus
);

  state_t      state;
  logic [8:0]  idx;
  logic [15:0] dly_cnt;
  logic [15:0] to_cnt;
  logic [7:0]  retry_cnt;
  logic        ack_q;
  logic        host_mode;
  entry_t      rom_entry;

  i2c_seq_rom u_rom (
    .idx   (idx[7:0]),
    .entry (rom_entry)
  );

  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N) begin
      state             <= S_PWRUP;
      idx               <= '0;
      dly_cnt           <= '0;
      to_cnt            <= '0;
      retry_cnt         <= '0;
      ack_q             <= 1'b0;
      host_mode         <= 1'b0;
      bus.GO            <= 1'b0;
      bus.SLAVE_ADDRESS <= '0;
      bus.POINTER       <= '0;
      bus.WDATA8        <= '0;
      bus.INIT_DONE     <= 1'b0;
      bus.INIT_ERR      <= 1'b0;
      bus.ERR_INDEX     <= '0;
`ifdef I2C_SEQ_HOST_PORT_EN
      bus.HOST_ACK      <= 1'b0;
      bus.HOST_NACK     <= 1'b0;
`endif
    end else begin
`ifdef I2C_SEQ_HOST_PORT_EN
      bus.HOST_ACK  <= 1'b0;
      bus.HOST_NACK <= 1'b0;
`endif
      case (state)
        S_PWRUP: begin
          if (dly_cnt < 16'(PWRUP_DLY))
            dly_cnt <= dly_cnt + 16'd1;
          else if (bus.END_OK)
            state <= S_FETCH;
        end
        S_FETCH: begin
          if (idx == 9'(N_ENTRIES) ||
              rom_entry.slave == END_MARK) begin
            bus.INIT_DONE <= !bus.INIT_ERR;
            state         <= S_DONE;
          end else begin
            bus.SLAVE_ADDRESS <= rom_entry.slave;
            bus.POINTER       <= rom_entry.ptr;
            bus.WDATA8        <= rom_entry.data;
            state             <= S_GO_HI;
          end
        end
        // A stuck engine (END_OK low) blocks any new GO here
        S_GO_HI: begin
          if (!bus.GO) begin
            if (bus.END_OK) begin
              bus.GO  <= 1'b1;
              dly_cnt <= 16'd1;
            end
          end else if (dly_cnt >= 16'(GO_HOLD)) begin
            bus.GO <= 1'b0;
            to_cnt <= '0;
            state  <= S_WAIT_LO;
          end else begin
            dly_cnt <= dly_cnt + 16'd1;
          end
        end
        S_WAIT_LO: begin
          if (!bus.END_OK) begin
            ack_q  <= 1'b0;
            to_cnt <= '0;
            state  <= S_WAIT_HI;
          end else if (to_cnt >= 16'(TIMEOUT)) begin
            ack_q <= 1'b0;
            state <= S_CHECK;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        // ACK_OK drops with the END_OK rise, so keep the last busy sample
        S_WAIT_HI: begin
          if (bus.END_OK) begin
            state <= S_CHECK;
          end else if (to_cnt >= 16'(TIMEOUT)) begin
            ack_q <= 1'b0;
            state <= S_CHECK;
          end else begin
            ack_q  <= bus.ACK_OK;
            to_cnt <= to_cnt + 16'd1;
          end
        end
        S_CHECK: begin
          if (host_mode) begin
            host_mode <= 1'b0;
`ifdef I2C_SEQ_HOST_PORT_EN
            bus.HOST_ACK  <= ack_q;
            bus.HOST_NACK <= !ack_q;
`endif
            state <= bus.INIT_ERR ? S_ERR : S_DONE;
          end else if (ack_q) begin
            idx       <= idx + 9'd1;
            retry_cnt <= '0;
            state     <= S_FETCH;
          end else if (int'(retry_cnt) < MAX_RETRY) begin
            retry_cnt <= retry_cnt + 8'd1;
            dly_cnt   <= '0;
            state     <= S_RETRY;
          end else begin
            if (!bus.INIT_ERR)
              bus.ERR_INDEX <= idx[7:0];
            bus.INIT_ERR <= 1'b1;
            state        <= S_ERR;
          end
        end
        S_RETRY: begin
          if (dly_cnt >= 16'(RETRY_GAP - 1))
            state <= S_GO_HI;
          else
            dly_cnt <= dly_cnt + 16'd1;
        end
        S_DONE, S_ERR: begin
`ifdef I2C_SEQ_HOST_PORT_EN
          if (bus.HOST_REQ && bus.END_OK) begin
            host_mode         <= 1'b1;
            bus.SLAVE_ADDRESS <= bus.HOST_SLAVE;
            bus.POINTER       <= bus.HOST_PTR;
            bus.WDATA8        <= bus.HOST_DATA;
            state             <= S_GO_HI;
          end
`endif
        end
        default: state <= S_PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Bench for i2c_write_sequencer: engine BFM, GO-edge scoreboard monitor,
// directed init scenarios; host scenario built with I2C_SEQ_HOST_PORT_EN.
module tb_i2c_write_sequencer;
  import i2c_seq_pkg::*;

  localparam int PWRUP_DLY = 255;
  localparam int GO_HOLD   = 2;
  localparam int MAX_RETRY = 3;
  localparam int TIMEOUT   = 1023;

  localparam entry_t E0 = 24'h34_10_01;
  localparam entry_t E1 = 24'h34_11_22;
  localparam entry_t E2 = 24'h1A_05_7F;
  localparam entry_t EH = 24'h50_01_A5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_write_sequencer_if bus();

  i2c_write_sequencer #(
    .N_ENTRIES (8),
    .PWRUP_DLY (PWRUP_DLY),
    .GO_HOLD   (GO_HOLD),
    .MAX_RETRY (MAX_RETRY),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .PT_CK   (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  entry_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int mode     = 0;
  int busy_len = 6;
  int attempts[256];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // mode 0: ack all, 1: NACK pointer 0x11 once, 2: NACK 0x05 always, 3: stuck
  function automatic logic decide(input logic [7:0] p);
    attempts[p]++;
    case (mode)
      1:       return !(p == 8'h11 && attempts[p] == 1);
      2:       return p != 8'h05;
      default: return 1'b1;
    endcase
  endfunction

  initial begin
    logic [7:0] p;
    bus.END_OK = 1'b1;
    bus.ACK_OK = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.GO && mode != 3) begin
        p = bus.POINTER;
        while (bus.GO) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        bus.ACK_OK = decide(p);
        bus.END_OK = 1'b0;
        repeat (busy_len) @(posedge clk);
        #1;
        bus.END_OK = 1'b1;
        bus.ACK_OK = 1'b0;
      end
    end
  end

  initial begin
    logic   prev;
    int     width;
    entry_t got;
    entry_t e;
    prev  = 1'b0;
    width = 0;
    forever begin
      @(posedge clk); #1;
      if (bus.GO && !prev) begin
        got = '{bus.SLAVE_ADDRESS, bus.POINTER, bus.WDATA8};
        check("go_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("go_entry", 32'(got), 32'(e));
        end
        width = 1;
      end else if (bus.GO) begin
        width++;
      end else if (prev) begin
        check("go_width", width, GO_HOLD);
      end
      prev = bus.GO;
    end
  end

  task automatic apply_reset(input int m);
    rst_n = 1'b0;
    mode = m;
    busy_len = 6;
    exp_q.delete();
    for (int i = 0; i < 256; i++) attempts[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_go", 32'(bus.GO), 0);
    check("rst_done", 32'(bus.INIT_DONE), 0);
    check("rst_err", 32'(bus.INIT_ERR), 0);
    rst_n = 1'b1;
  endtask

  task automatic wait_end(input int bound);
    int n = 0;
    while (!(bus.INIT_DONE || bus.INIT_ERR) && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    check("end_reached", 32'(n < bound), 1);
  endtask

  task automatic finish_scn(input logic done, input logic err,
                            input logic [7:0] eidx);
    repeat (80) @(posedge clk);
    #1;
    check("init_done", 32'(bus.INIT_DONE), 32'(done));
    check("init_err", 32'(bus.INIT_ERR), 32'(err));
    check("err_index", 32'(bus.ERR_INDEX), 32'(eidx));
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    int eo;
`ifdef I2C_SEQ_HOST_PORT_EN
    bus.HOST_REQ   = 1'b0;
    bus.HOST_SLAVE = 8'h00;
    bus.HOST_PTR   = 8'h00;
    bus.HOST_DATA  = 8'h00;
`endif

    apply_reset(0);
    exp_q.push_back(E0);
    exp_q.push_back(E1);
    exp_q.push_back(E2);
`ifdef I2C_SEQ_HOST_PORT_EN
    bus.HOST_SLAVE = EH.slave;
    bus.HOST_PTR   = EH.ptr;
    bus.HOST_DATA  = EH.data;
    bus.HOST_REQ   = 1'b1;
    exp_q.push_back(EH);
    wait_end(20000);
    n = 0;
    while (!bus.HOST_ACK && n < 3000) begin @(posedge clk); #1; n++; end
    check("host_ack_seen", 32'(n < 3000), 1);
    check("host_nack", 32'(bus.HOST_NACK), 0);
    bus.HOST_REQ = 1'b0;
    @(posedge clk); #1;
    check("host_ack_pulse", 32'(bus.HOST_ACK), 0);
`else
    wait_end(20000);
`endif
    finish_scn(1'b1, 1'b0, 8'd0);

    apply_reset(1);
    exp_q.push_back(E0);
    exp_q.push_back(E1);
    exp_q.push_back(E1);
    exp_q.push_back(E2);
    wait_end(20000);
    finish_scn(1'b1, 1'b0, 8'd0);

    apply_reset(2);
    exp_q.push_back(E0);
    exp_q.push_back(E1);
    for (int i = 0; i <= MAX_RETRY; i++) exp_q.push_back(E2);
    wait_end(20000);
    finish_scn(1'b0, 1'b1, 8'd2);

    apply_reset(3);
    for (int i = 0; i <= MAX_RETRY; i++) exp_q.push_back(E0);
    wait_end(20000);
    finish_scn(1'b0, 1'b1, 8'd0);

    apply_reset(0);
    busy_len = 400;
    exp_q.push_back(E0);
    n = 0;
    while (bus.END_OK && n < 3000) begin @(posedge clk); #1; n++; end
    check("reached_busy", 32'(n < 3000), 1);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_go", 32'(bus.GO), 0);
    check("mid_rst_addr", 32'(bus.SLAVE_ADDRESS), 0);
    check("mid_rst_ptr", 32'(bus.POINTER), 0);
    check("mid_rst_data", 32'(bus.WDATA8), 0);
    check("mid_rst_done", 32'(bus.INIT_DONE), 0);
    check("mid_rst_err", 32'(bus.INIT_ERR), 0);
    check("mid_rst_eidx", 32'(bus.ERR_INDEX), 0);
    exp_q.push_back(E0);
    exp_q.push_back(E1);
    exp_q.push_back(E2);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    eo = -1;
    while (!bus.GO && n < 5000) begin
      @(posedge clk); #1;
      n++;
      if (bus.END_OK && eo < 0) eo = n;
    end
    check("restart_go_seen", 32'(n < 5000), 1);
    check("restart_pwrup", 32'(n >= PWRUP_DLY), 1);
    check("restart_endok", 32'(eo >= 0 && eo < n), 1);
    wait_end(20000);
    finish_scn(1'b1, 1'b0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
